logic_reduce_acc: RTL
=====================

LOGIC_REDUCE_ACC -- requirements
Module: logic_reduce_acc

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width in bits (>=1).
REQ-002 SHALL have parameter MAX_BEATS, default 16, maximum beats per packet (>=1).
REQ-003 SHALL derive CNT_W = $clog2(MAX_BEATS+1) for the beat counter and out_count width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-006 SHALL have port op  input  2  operation: 00 AND, 01 OR, 10 XOR, 11 NAND; sampled on first beat only.
REQ-007 SHALL have port in_valid  input  1  input beat valid.
REQ-008 SHALL have port in_ready  output  1  block can accept a beat.
REQ-009 SHALL have port in_data  input  WIDTH  operand word.
REQ-010 SHALL have port in_last  input  1  final beat of packet.
REQ-011 SHALL have port out_valid  output  1  result valid.
REQ-012 SHALL have port out_ready  input  1  consumer accepts result.
REQ-013 SHALL have port out_data  output  WIDTH  bitwise reduction result.
REQ-014 SHALL have port out_count  output  CNT_W  beats accumulated in packet.
REQ-015 SHALL have port out_trunc  output  1  packet terminated at MAX_BEATS without in_last.

Function
REQ-016 SHALL implement FSM states IDLE, ACC, HOLD.
REQ-017 SHALL accept a beat only when in_valid && in_ready; in_ready = 1 in IDLE and ACC, 0 in HOLD.
REQ-018 IDLE accept: acc <= in_data, op latched, count <= 1; -> HOLD if in_last or MAX_BEATS==1, else -> ACC.
REQ-019 ACC accept: acc <= acc AND/OR/XOR in_data per latched op (NAND accumulates as AND), count <= count+1.
REQ-020 ACC -> HOLD when accepted beat has in_last=1, or count+1 == MAX_BEATS.
REQ-021 out_trunc SHALL be 1 only when HOLD entered via MAX_BEATS with in_last=0 on that beat.
REQ-022 out_valid SHALL be 1 exactly in HOLD; result valid the cycle after the terminating beat is accepted (latency 1).
REQ-023 out_data SHALL equal acc, or ~acc when latched op = NAND; out_data/out_count/out_trunc stable throughout HOLD.
REQ-024 HOLD -> IDLE on out_valid && out_ready; no beat accepted in that cycle.
REQ-025 op changes after first beat SHALL be ignored until next packet.
REQ-026 ACC with in_valid=0 SHALL hold state and acc; no timeout.
REQ-027 Beats arriving after a truncation SHALL start a new packet.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, acc=0, count=0, latched op=00, out_valid=0, out_data=0, out_count=0, out_trunc=0.
REQ-029 Reset mid-packet (ACC or HOLD) SHALL discard partial/pending result; no output produced for it.
REQ-030 in_ready SHALL be 1 from first clk edge after rst_n deasserts.

Structure
REQ-031 Shared package SHALL hold op encodings (OP_AND, OP_OR, OP_XOR, OP_NAND) and state encodings.
REQ-032 Combinational op function SHALL be a sub-module logic_op_alu (inputs a, b, op; output y), instantiated once.

Verification (WIDTH=8, MAX_BEATS=4)
REQ-033 AND: F0, 3C, FF(last) -> out_data=30, out_count=3, out_trunc=0, out_valid the cycle after last accept.
REQ-034 XOR single beat A5(last) -> out_data=A5, out_count=1; NAND FF, 0F(last) -> out_data=F0, out_count=2.
REQ-035 OR: 01, 02, 04, 08, none last -> out_data=0F, out_count=4, out_trunc=1; following beat 10(last) -> separate result 10, count 1.
REQ-036 Backpressure: out_ready=0 for 5 cycles in HOLD -> out_data stable, in_ready=0; out_ready=1 -> IDLE next cycle, in_ready=1.
REQ-037 op changed from AND to OR mid-packet: 0F, F0(last) -> out_data=00.
REQ-038 rst_n pulsed low in ACC -> all outputs 0 immediately; next packet AND C3(last) -> out_data=C3, out_count=1.

Source files
------------

// File: rtl/logic_reduce_acc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : logic_reduce_acc_pkg
// Description : Shared operation and FSM state encodings for logic_reduce_acc.
// Revision    : 1.0 - initial release
// ============================================================================
package logic_reduce_acc_pkg;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_NAND = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ACC  = 2'b01,
    ST_HOLD = 2'b10
  } state_e;

endpackage
`default_nettype wire

// File: rtl/logic_op_alu.sv
`default_nettype none
// ============================================================================
// Module      : logic_op_alu
// Description : Combinational bitwise AND/OR/XOR/NAND of two words.
// Revision    : 1.0 - initial release
// ============================================================================
module logic_op_alu
  import logic_reduce_acc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_e              op,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NAND: y = ~(a & b);
      default: y = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/logic_reduce_acc.sv
`default_nettype none
// ============================================================================
// Module      : logic_reduce_acc
// Description : Streams packet beats into a bitwise reduction and presents
//               the result with a beat count and truncation flag.
// Revision    : 1.0 - initial release
// ============================================================================
module logic_reduce_acc
  import logic_reduce_acc_pkg::*;
#(
  parameter  int WIDTH     = 8,
  parameter  int MAX_BEATS = 16,
  localparam int CNT_W     = $clog2(MAX_BEATS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       op,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_trunc
);

  localparam bit       SINGLE_BEAT = (MAX_BEATS == 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BEATS);

  state_e           state_q;
  logic [WIDTH-1:0] acc_q;
  op_e              op_q;
  logic [CNT_W-1:0] count_q;
  logic             trunc_q;

  op_e              alu_op;
  logic [WIDTH-1:0] alu_y;
  logic [CNT_W-1:0] cnt_inc;

  // NAND packets accumulate as AND; the inversion is applied only at the output.
  assign alu_op  = (op_q == OP_NAND) ? OP_AND : op_q;
  assign cnt_inc = count_q + CNT_W'(1);

  logic_op_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .a  (acc_q),
    .b  (in_data),
    .op (alu_op),
    .y  (alu_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      op_q    <= OP_AND;
      count_q <= '0;
      trunc_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            acc_q   <= in_data;
            op_q    <= op_e'(op);
            count_q <= CNT_W'(1);
            trunc_q <= SINGLE_BEAT && !in_last;
            state_q <= (in_last || SINGLE_BEAT) ? ST_HOLD : ST_ACC;
          end
        end
        ST_ACC: begin
          if (in_valid) begin
            acc_q   <= alu_y;
            count_q <= cnt_inc;
            if (in_last) begin
              trunc_q <= 1'b0;
              state_q <= ST_HOLD;
            end else if (cnt_inc == MAX_CNT) begin
              trunc_q <= 1'b1;
              state_q <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            trunc_q <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q != ST_HOLD);
  assign out_valid = (state_q == ST_HOLD);
  assign out_data  = (op_q == OP_NAND) ? ~acc_q : acc_q;
  assign out_count = count_q;
  assign out_trunc = trunc_q;

endmodule
`default_nettype wire
